// File: rtl/alu_seq_unit.sv
// alu_seq_unit: operand/ALU/flag datapath with FSM-sequenced shift-add multiply; optional multiplier via ALU_MUL_EN
module alu_seq_unit #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] DISP_IDLE = 32'hE0E0E0E0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] sw,
  input  logic            ld_a,
  input  logic            ld_b,
  input  logic            go,
  input  logic [3:0]      op,
  input  logic [1:0]      out_sel,
  output logic            busy,
  output logic            done,
  output logic [3:0]      fr,
  output logic [31:0]     disp_data
);
  localparam int SW = $clog2(XLEN);
  localparam logic [0:0] IDLE = 1'b0, EXEC = 1'b1;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, f_q, f_d, res;
  logic [3:0] fr_q, fr_d, op_q, op_d;
  logic [0:0] state_q, state_d;
  logic done_q, done_d, ld_a_q, ld_b_q, go_q, ld_a_p, ld_b_p, go_p, cf, of;
  logic [31:0] disp_q, disp_d;
  logic [XLEN:0] sum, dif;
`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] prod_q, prod_d, pnext;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [XLEN:0] msum;
  assign msum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({(XLEN+1){prod_q[0]}} & {1'b0, a_q});
  assign pnext = {msum, prod_q[XLEN-1:1]};
`endif
  assign ld_a_p    = ld_a & ~ld_a_q;
  assign ld_b_p    = ld_b & ~ld_b_q;
  assign go_p      = go & ~go_q;
  assign busy      = state_q == EXEC;
  assign done      = done_q;
  assign fr        = fr_q;
  assign disp_data = disp_q;
  // single-cycle ALU result and carry/overflow for the latched op
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    dif = {1'b0, a_q} - {1'b0, b_q};
    res = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (op_q)
      4'd0: res = a_q & b_q;
      4'd1: res = a_q | b_q;
      4'd2: res = a_q ^ b_q;
      4'd3: res = ~(a_q | b_q);
      4'd4: begin
        res = sum[XLEN-1:0];
        cf  = sum[XLEN];
        of  = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
      end
      4'd5: begin
        res = dif[XLEN-1:0];
        cf  = dif[XLEN];
        of  = (a_q[XLEN-1] != b_q[XLEN-1]) && (dif[XLEN-1] != a_q[XLEN-1]);
      end
      4'd6: res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      4'd7: res = a_q << b_q[SW-1:0];
      default: res = '0;
    endcase
  end
  // operand loads, FSM sequencing, result/flag capture and display select
  always_comb begin
    a_d     = (state_q == IDLE && ld_a_p) ? sw : a_q;
    b_d     = (state_q == IDLE && ld_b_p) ? sw : b_q;
    op_d    = (state_q == IDLE && go_p) ? op : op_q;
    state_d = state_q;
    f_d     = f_q;
    fr_d    = fr_q;
    done_d  = 1'b0;
    disp_d  = out_sel == 2'b00 ? DISP_IDLE : out_sel == 2'b01 ? 32'(a_q) : out_sel == 2'b10 ? 32'(b_q) : 32'(f_q);
`ifdef ALU_MUL_EN
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    if (state_q == IDLE) begin
      if (go_p) begin
        state_d = EXEC;
`ifdef ALU_MUL_EN
        prod_d  = {{XLEN{1'b0}}, b_d};
        cnt_d   = SW'(XLEN - 1);
`endif
      end
    end
`ifdef ALU_MUL_EN
    else if (op_q == 4'd8) begin
      prod_d = pnext;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
        f_d     = pnext[XLEN-1:0];
        fr_d    = {pnext[XLEN-1:0] == '0, pnext[XLEN-1], |pnext[2*XLEN-1:XLEN], |pnext[2*XLEN-1:XLEN]};
      end
    end
`endif
    else begin
      state_d = IDLE;
      done_d  = 1'b1;
      f_d     = res;
      fr_d    = {res == '0, res[XLEN-1], cf, of};
    end
  end
  // state registers with synchronous reset; a reset mid-op aborts without done
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      fr_q    <= '0;
      op_q    <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
      ld_a_q  <= 1'b0;
      ld_b_q  <= 1'b0;
      go_q    <= 1'b0;
      disp_q  <= DISP_IDLE;
`ifdef ALU_MUL_EN
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      fr_q    <= fr_d;
      op_q    <= op_d;
      state_q <= state_d;
      done_q  <= done_d;
      ld_a_q  <= ld_a;
      ld_b_q  <= ld_b;
      go_q    <= go;
      disp_q  <= disp_d;
`ifdef ALU_MUL_EN
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: table-driven and directed checks of alu_seq_unit (XLEN=32 and XLEN=8 instances)
module tb_alu_seq_unit;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif
  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] f;
    logic [3:0]  fr;
  } vec_t;
  logic clk = 0, rst = 1, ld_a = 0, ld_b = 0, go = 0;
  logic [31:0] sw = 0;
  logic [3:0] op = 0;
  logic [1:0] out_sel = 2'b11;
  logic busy, done, busy8, done8;
  logic [3:0] fr, fr8;
  logic [31:0] disp, disp8;
  int checks = 0, errors = 0, done_cnt = 0, lat;
  vec_t v[16];
  always #5 clk = ~clk;
  alu_seq_unit dut (.clk(clk), .rst(rst), .sw(sw), .ld_a(ld_a), .ld_b(ld_b), .go(go), .op(op),
    .out_sel(out_sel), .busy(busy), .done(done), .fr(fr), .disp_data(disp));
  alu_seq_unit #(.XLEN(8)) u8 (.clk(clk), .rst(rst), .sw(sw[7:0]), .ld_a(ld_a), .ld_b(ld_b), .go(go), .op(op),
    .out_sel(out_sel), .busy(busy8), .done(done8), .fr(fr8), .disp_data(disp8));
  always @(negedge clk) if (done) done_cnt++;
  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task load(input logic [31:0] a, input logic [31:0] b);
    sw = a; ld_a = 1; tick;
    ld_a = 0; sw = b; ld_b = 1; tick;
    ld_b = 0;
  endtask
  task run(input logic [3:0] o, output int l);
    op = o; go = 1; tick;
    go = 0; l = 1;
    while (!done && l < 100) begin tick; l++; end
    tick;
  endtask
  initial begin
    v[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'd4, 32'h80000000, 4'b0101};
    v[1]  = '{32'h00000003, 32'h00000005, 4'd5, 32'hFFFFFFFE, 4'b0110};
    v[2]  = '{32'h00000003, 32'h00000005, 4'd6, 32'h00000001, 4'b0000};
    v[3]  = '{32'hF0F000FF, 32'h0FF00F0F, 4'd0, 32'h00F0000F, 4'b0000};
    v[4]  = '{32'hF0F000FF, 32'h0FF00F0F, 4'd1, 32'hFFF00FFF, 4'b0100};
    v[5]  = '{32'hF0F000FF, 32'h0FF00F0F, 4'd2, 32'hFF000FF0, 4'b0100};
    v[6]  = '{32'h00000000, 32'h00000000, 4'd3, 32'hFFFFFFFF, 4'b0100};
    v[7]  = '{32'hFFFFFFFF, 32'h00000001, 4'd4, 32'h00000000, 4'b1010};
    v[8]  = '{32'h00000005, 32'h00000005, 4'd5, 32'h00000000, 4'b1000};
    v[9]  = '{32'h80000000, 32'h00000001, 4'd5, 32'h7FFFFFFF, 4'b0001};
    v[10] = '{32'hFFFFFFFF, 32'h00000001, 4'd6, 32'h00000001, 4'b0000};
    v[11] = '{32'h00000001, 32'h0000003F, 4'd7, 32'h80000000, 4'b0100};
    v[12] = '{32'h12345678, 32'h9ABCDEF0, 4'd9, 32'h00000000, 4'b1000};
    v[13] = '{32'h12345678, 32'h9ABCDEF0, 4'd15, 32'h00000000, 4'b1000};
`ifdef ALU_MUL_EN
    v[14] = '{32'h00010000, 32'h00010000, 4'd8, 32'h00000000, 4'b1011};
    v[15] = '{32'h00000006, 32'h00000007, 4'd8, 32'h0000002A, 4'b0000};
`else
    v[14] = '{32'h00010000, 32'h00010000, 4'd8, 32'h00000000, 4'b1000};
    v[15] = '{32'h00000006, 32'h00000007, 4'd8, 32'h00000000, 4'b1000};
`endif
    out_sel = 2'b01;
    repeat (2) tick;
    chk("rst fr", 32'(fr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst disp", disp, 32'hE0E0E0E0);
    rst = 0; tick;
    chk("disp A after rst", disp, 0);
    out_sel = 2'b11; tick;
    for (int i = 0; i < 16; i++) begin
      load(v[i].a, v[i].b);
      run(v[i].op, lat);
      chk($sformatf("v%0d latency", i), lat, v[i].op == 4'd8 ? MUL_LAT : 2);
      chk($sformatf("v%0d F", i), disp, v[i].f);
      chk($sformatf("v%0d fr", i), 32'(fr), 32'(v[i].fr));
      chk($sformatf("v%0d done pulse", i), 32'(done), 0);
      repeat (12) tick;
    end
    load(32'hFF, 32'h1);
    run(4'd4, lat);
    chk("x8 add F", disp8, 0);
    chk("x8 add fr", 32'(fr8), 32'(4'b1010));
    out_sel = 2'b00; tick;
    chk("disp idle", disp, 32'hE0E0E0E0);
    out_sel = 2'b11;
    load(32'h2, 32'h3);
    done_cnt = 0;
`ifdef ALU_MUL_EN
    op = 4'd8;
`else
    op = 4'd4;
`endif
    go = 1; tick;
    go = 0; op = 4'd0; sw = 32'hFF; ld_a = 1; tick;
    ld_a = 0;
`ifdef ALU_MUL_EN
    go = 1; tick;
    go = 0;
    repeat (40) tick;
    chk("busy F frozen op", disp, 32'h6);
`else
    repeat (5) tick;
    chk("busy F frozen op", disp, 32'h5);
`endif
    chk("busy single done", done_cnt, 1);
    out_sel = 2'b01; tick;
    chk("busy load dropped", disp, 32'h2);
    out_sel = 2'b11;
    done_cnt = 0;
    op = 4'd4; go = 1;
    repeat (10) tick;
    go = 0;
    repeat (40) tick;
    chk("go held one op", done_cnt, 1);
    chk("go held F", disp, 32'h5);
    sw = 32'h9; ld_a = 1; go = 1; op = 4'd4; tick;
    ld_a = 0; go = 0;
    repeat (3) tick;
    chk("go+load uses new A", disp, 32'hC);
    sw = 32'h55; ld_a = 1; ld_b = 1; tick;
    ld_a = 0; ld_b = 0;
    run(4'd2, lat);
    chk("dual load xor F", disp, 0);
    chk("dual load xor fr", 32'(fr), 32'(4'b1000));
    out_sel = 2'b10; tick;
    chk("dual load B", disp, 32'h55);
    out_sel = 2'b11;
    run(4'd4, lat);
    chk("pre-abort F", disp, 32'hAA);
    done_cnt = 0;
`ifdef ALU_MUL_EN
    op = 4'd8;
`else
    op = 4'd4;
`endif
    go = 1; tick;
    go = 0;
`ifdef ALU_MUL_EN
    repeat (5) tick;
`endif
    rst = 1; tick;
    rst = 0;
    chk("abort busy", 32'(busy), 0);
    chk("abort fr", 32'(fr), 0);
    tick;
    chk("abort F", disp, 0);
    repeat (40) tick;
    chk("abort no done", done_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
